// File: rtl/alu_nibble_sequencer_if.sv
// Request/response and slice-side signal bundle for alu_nibble_sequencer.
// slave  : the sequencer itself (takes requests, drives the ALU4Bit slice).
// master : the surrounding environment (controller plus the slice).
interface alu_nibble_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [2:0]       req_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_cout;
   logic             rsp_zero;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic             alu_cin;
   logic             alu_less;
   logic [2:0]       alu_op;
   logic [3:0]       alu_result;
   logic             alu_cout;
   logic             alu_set;

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
             alu_result, alu_cout, alu_set,
      output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero,
             alu_a, alu_b, alu_cin, alu_less, alu_op
   );

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
             alu_result, alu_cout, alu_set,
      input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero,
             alu_a, alu_b, alu_cin, alu_less, alu_op
   );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a WIDTH-bit ALU operation through one shared
// 4-bit ALU slice, one nibble per cycle LSB first, rippling the carry through
// a register between passes.
// Optional build macro SLT_OVF_FIX_EN: corrects the SLT sign for signed
// overflow; undefined, SLT reports the raw sign of A-B like the plain slice.
module alu_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst,
   alu_nibble_sequencer_if.slave bus
);
   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cout_q, cout_d;
   logic             zero_q, zero_d;
   logic             slt_s;

   // Bit offset of the nibble being processed this cycle.
   logic [IW+1:0]    nib_lsb;
   assign nib_lsb = {idx_q, 2'b00};

   // SLT decision bit taken from the top nibble's set output.
`ifdef SLT_OVF_FIX_EN
   logic ovf;
   assign ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (bus.alu_set != a_q[WIDTH-1]);
   assign slt_s = bus.alu_set ^ ovf;
`else
   assign slt_s = bus.alu_set;
`endif

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.rsp_valid  = (state_q == DONE);
   assign bus.rsp_result = res_q;
   assign bus.rsp_cout   = cout_q;
   assign bus.rsp_zero   = zero_q;

   // Slice drive: the current nibble pair in RUN, all zeros otherwise.
   always_comb begin
      bus.alu_a    = 4'h0;
      bus.alu_b    = 4'h0;
      bus.alu_cin  = 1'b0;
      bus.alu_less = 1'b0;
      bus.alu_op   = 3'b000;
      if (state_q == RUN) begin
         bus.alu_a   = a_q[nib_lsb +: 4];
         bus.alu_b   = b_q[nib_lsb +: 4];
         bus.alu_cin = carry_q;
         bus.alu_op  = op_q;
      end
   end

   // Next state: latch the request, accumulate nibbles, finalise on the last pass.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      res_d   = res_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               a_d     = bus.req_a;
               b_d     = bus.req_b;
               op_d    = bus.req_op;
               idx_d   = '0;
               // Subtract-type ops run as A + ~B + 1.
               carry_d = (bus.req_op == OP_SUB) || (bus.req_op == OP_SLT);
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[nib_lsb +: 4] = bus.alu_result;
            carry_d             = bus.alu_cout;
            if (idx_q == IW'(N - 1)) begin
               case (op_q)
                  OP_AND, OP_OR: begin
                     res_d  = acc_d;
                     cout_d = 1'b0;
                  end
                  OP_ADD, OP_SUB: begin
                     res_d  = acc_d;
                     cout_d = bus.alu_cout;
                  end
                  OP_SLT: begin
                     res_d  = {{(WIDTH-1){1'b0}}, slt_s};
                     cout_d = bus.alu_cout;
                  end
                  default: begin
                     // Illegal op: slice was still cycled, result is suppressed.
                     res_d  = '0;
                     cout_d = 1'b0;
                  end
               endcase
               zero_d  = (res_d == '0);
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 3'b000;
         idx_q   <= '0;
         carry_q <= 1'b0;
         acc_q   <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
      end
   end
endmodule
